// File: rtl/controle_contador_pkg.sv
// Shared definitions for the counter control stage.
//   LARGURA  : width of the shift/ring counter driven by this block
//   modo_t   : {ch1,ch0} mode-select encoding understood by the counter
//   estado_t : control FSM states (2 bits)
package controle_contador_pkg;

  localparam int LARGURA = 7;

  typedef enum logic [1:0] {
    MODO_HOLD  = 2'b00,
    MODO_SHIFT = 2'b01,
    MODO_LOAD  = 2'b10,
    MODO_CLEAR = 2'b11
  } modo_t;

  typedef enum logic [1:0] {
    EST_HOLD  = 2'b00,
    EST_RUN   = 2'b01,
    EST_LOAD  = 2'b10,
    EST_CLEAR = 2'b11
  } estado_t;

endpackage

// File: rtl/sincroniza_botao.sv
// Button synchroniser and rising-edge detector.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   btn   : raw asynchronous button level
//   borda : one-cycle pulse, one clock after the synchronised level rises
// A level sampled high at edge k yields borda high between edges k+1 and
// k+2, so a registered consumer reacts at edge k+2.
module sincroniza_botao (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic borda
);

  logic sync1;
  logic sync2;
  logic prev;
  logic cheio;
  logic armado;

  // armado is only set once the button has been sampled low after reset,
  // so a button held through reset never counts as a press. cheio marks
  // that sync1 holds a real sample rather than its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      cheio  <= 1'b0;
      armado <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      cheio <= 1'b1;
      if (cheio && !sync1) begin
        armado <= 1'b1;
      end
    end
  end

  assign borda = sync2 & ~prev & armado;

endmodule

// File: rtl/controle_contador.sv
// Control stage in front of the 7-bit shift/ring counter.
//   clk, rst        : clock, asynchronous active-high reset
//   btn_load/run/clr: raw buttons (parallel load, run/stop toggle, clear)
//   sw_dado         : parallel load value (bit0 -> counter bit0)
//   sw_serial       : serial value fed to d while running
//   ch1, ch0        : mode select to counter (00 hold, 01 shift, 10 load, 11 clear)
//   d               : serial input to counter
//   bits            : parallel load word
//   passo           : shifts done in the current rotation, 0..PASSOS-1
//   volta           : one-cycle pulse when passo wraps to 0
//   rodando         : run flag
// All outputs come straight from flops.
module controle_contador
  import controle_contador_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int PASSOS = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_load,
  input  logic               btn_run,
  input  logic               btn_clr,
  input  logic [LARGURA-1:0] sw_dado,
  input  logic               sw_serial,
  output logic               ch1,
  output logic               ch0,
  output logic               d,
  output logic [LARGURA-1:0] bits,
  output logic [2:0]         passo,
  output logic               volta,
  output logic               rodando
);

  localparam int PW = $clog2(DIV);

  logic ev_load;
  logic ev_run;
  logic ev_clr;

  sincroniza_botao u_sinc_load (.clk(clk), .rst(rst), .btn(btn_load), .borda(ev_load));
  sincroniza_botao u_sinc_run  (.clk(clk), .rst(rst), .btn(btn_run),  .borda(ev_run));
  sincroniza_botao u_sinc_clr  (.clk(clk), .rst(rst), .btn(btn_clr),  .borda(ev_clr));

  // FSM state is kept in estado for observation alongside the outputs.
  estado_t            estado,  estado_prox;
  modo_t              modo,    modo_prox;
  logic               d_prox;
  logic [LARGURA-1:0] bits_prox;
  logic [2:0]         passo_prox;
  logic               volta_prox;
  logic               rodando_prox;
  logic [PW-1:0]      presc,   presc_prox;

  always_comb begin
    estado_prox  = estado;
    modo_prox    = MODO_HOLD;
    d_prox       = d;
    bits_prox    = bits;
    passo_prox   = passo;
    volta_prox   = 1'b0;
    rodando_prox = rodando;
    presc_prox   = presc;

    if (estado == EST_RUN) begin
      d_prox = sw_serial;
    end

    case (estado)
      // One-shot states: any button edge arriving now is consumed.
      EST_LOAD, EST_CLEAR: begin
        estado_prox = rodando ? EST_RUN : EST_HOLD;
        presc_prox  = '0;
      end
      default: begin
        // clr beats load beats run toggle; losers are dropped, and an event
        // pre-empts a prescaler tick in the same cycle.
        if (ev_clr) begin
          estado_prox = EST_CLEAR;
          modo_prox   = MODO_CLEAR;
          bits_prox   = '0;
          passo_prox  = '0;
        end else if (ev_load) begin
          estado_prox = EST_LOAD;
          modo_prox   = MODO_LOAD;
          bits_prox   = sw_dado;
          passo_prox  = '0;
        end else if (ev_run) begin
          rodando_prox = ~rodando;
          estado_prox  = rodando ? EST_HOLD : EST_RUN;
          presc_prox   = '0;
        end else if (estado == EST_RUN) begin
          if (presc == PW'(DIV - 1)) begin
            presc_prox = '0;
            modo_prox  = MODO_SHIFT;
            if (passo == 3'(PASSOS - 1)) begin
              passo_prox = '0;
              volta_prox = 1'b1;
            end else begin
              passo_prox = passo + 3'd1;
            end
          end else begin
            presc_prox = presc + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado  <= EST_HOLD;
      modo    <= MODO_HOLD;
      d       <= 1'b0;
      bits    <= '0;
      passo   <= '0;
      volta   <= 1'b0;
      rodando <= 1'b0;
      presc   <= '0;
    end else begin
      estado  <= estado_prox;
      modo    <= modo_prox;
      d       <= d_prox;
      bits    <= bits_prox;
      passo   <= passo_prox;
      volta   <= volta_prox;
      rodando <= rodando_prox;
      presc   <= presc_prox;
    end
  end

  assign ch1 = modo[1];
  assign ch0 = modo[0];

endmodule
